// File: rtl/ex_div_if.sv
// Handshake and data bundle between the execute stage and the divider.
`timescale 1ns/1ps
interface ex_div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    // Execute stage side: issues requests, consumes the result.
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    // Divider side: accepts requests, produces the result.
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/ex_div.sv
// Multi-cycle restoring divider for DIV/DIVU.
// The result packs the remainder in [63:32] (HI) and the quotient in [31:0] (LO).
// A nonzero divisor takes 32 iterations after the accept edge.
// A zero divisor bypasses the datapath and returns zero.
`timescale 1ns/1ps
module ex_div (
    input  logic    clk,
    input  logic    rst,
    ex_div_if.slave bus
);

    typedef enum logic [1:0] {
        DIV_FREE    = 2'd0,
        DIV_BY_ZERO = 2'd1,
        DIV_ON      = 2'd2,
        DIV_END     = 2'd3
    } div_state_t;

    // Two's-complement magnitude of v when is_neg is set, otherwise v unchanged.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_neg);
        logic [31:0] m;
        if (is_neg) begin
            m = ~v + 32'd1;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // One restoring shift-subtract step.
    // Layout: w = {33-bit partial remainder, 32-bit quotient}.
    // Bits w[64:31] are the shifted partial remainder extended to 34 bits,
    // so the borrow out of the subtract decides the new quotient bit.
    function automatic logic [64:0] iterate(input logic [64:0] w, input logic [31:0] d);
        logic [33:0] diff;
        logic [64:0] nxt;
        diff = w[64:31] - {2'b00, d};
        if (diff[33]) begin
            nxt = {w[63:31], w[30:0], 1'b0};
        end else begin
            nxt = {diff[32:0], w[30:0], 1'b1};
        end
        return nxt;
    endfunction

    // Apply the signed-mode corrections to a finished working register.
    // The output is {remainder, quotient}.
    function automatic logic [63:0] correct_sign(input logic [64:0] w, input logic neg_q,
                                                 input logic neg_rem);
        return {magnitude(w[63:32], neg_rem), magnitude(w[31:0], neg_q)};
    endfunction

    div_state_t  state_r, state_s;
    logic [4:0]  cnt_r, cnt_s;
    logic [64:0] work_r, work_s;
    logic [31:0] divisor_r, divisor_s;
    logic        neg_q_r, neg_q_s;
    logic        neg_rem_r, neg_rem_s;
    logic [63:0] result_r, result_s;
    logic        ready_r, ready_s;
    logic [64:0] iter_s;
    logic        dividend_neg_s;
    logic        divisor_neg_s;

    assign iter_s         = iterate(work_r, divisor_r);
    assign dividend_neg_s = bus.signed_div_i & bus.opdata1_i[31];
    assign divisor_neg_s  = bus.signed_div_i & bus.opdata2_i[31];

    assign bus.result_o = result_r;
    assign bus.ready_o  = ready_r;

    // Register the FSM state, datapath and outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= DIV_FREE;
            cnt_r     <= 5'd0;
            work_r    <= 65'd0;
            divisor_r <= 32'd0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            result_r  <= 64'd0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            work_r    <= work_s;
            divisor_r <= divisor_s;
            neg_q_r   <= neg_q_s;
            neg_rem_r <= neg_rem_s;
            result_r  <= result_s;
            ready_r   <= ready_s;
        end
    end

    // Compute the next state, the datapath update and the next output values.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        work_s    = work_r;
        divisor_s = divisor_r;
        neg_q_s   = neg_q_r;
        neg_rem_s = neg_rem_r;
        result_s  = result_r;
        ready_s   = ready_r;

        case (state_r)
            DIV_FREE: begin
                ready_s  = 1'b0;
                result_s = 64'd0;
                cnt_s    = 5'd0;
                if (bus.start_i && !bus.annul_i) begin
                    // Operands and sign flags are captured here.
                    // Later input changes cannot reach the result.
                    work_s    = {33'd0, magnitude(bus.opdata1_i, dividend_neg_s)};
                    divisor_s = magnitude(bus.opdata2_i, divisor_neg_s);
                    neg_q_s   = dividend_neg_s ^ divisor_neg_s;
                    neg_rem_s = dividend_neg_s;
                    if (bus.opdata2_i == 32'd0) begin
                        state_s = DIV_BY_ZERO;
                    end else begin
                        state_s = DIV_ON;
                    end
                end else begin
                    state_s = DIV_FREE;
                end
            end

            DIV_BY_ZERO: begin
                state_s  = DIV_END;
                result_s = 64'd0;
                ready_s  = 1'b1;
            end

            DIV_ON: begin
                if (bus.annul_i) begin
                    // Pipeline flush: drop the operation without producing a result.
                    state_s  = DIV_FREE;
                    cnt_s    = 5'd0;
                    work_s   = 65'd0;
                    result_s = 64'd0;
                    ready_s  = 1'b0;
                end else begin
                    work_s = iter_s;
                    cnt_s  = cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        state_s  = DIV_END;
                        result_s = correct_sign(iter_s, neg_q_r, neg_rem_r);
                        ready_s  = 1'b1;
                    end else begin
                        state_s = DIV_ON;
                    end
                end
            end

            DIV_END: begin
                if (bus.start_i) begin
                    state_s = DIV_END;
                    ready_s = 1'b1;
                end else begin
                    state_s  = DIV_FREE;
                    result_s = 64'd0;
                    ready_s  = 1'b0;
                end
            end

            default: begin
                state_s  = DIV_FREE;
                cnt_s    = 5'd0;
                work_s   = 65'd0;
                result_s = 64'd0;
                ready_s  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst`: input, 1 bit, asynchronous, active-high reset.
REQ-003 The block SHALL have the port `signed_div_i`: input, 1 bit; 1 selects signed (DIV), 0 selects unsigned (DIVU).
REQ-004 The block SHALL have the port `opdata1_i`: input, 32 bits, dividend, taken from the execute stage's reg1 operand.
REQ-005 The block SHALL have the port `opdata2_i`: input, 32 bits, divisor, taken from the execute stage's reg2 operand.
REQ-006 The block SHALL have the port `start_i`: input, 1 bit, divide request from the execute stage, held high until the result is taken.
REQ-007 The block SHALL have the port `annul_i`: input, 1 bit, aborts an in-progress divide (pipeline flush).
REQ-008 The block SHALL have the port `result_o`: output, 64 bits; [63:32] = remainder (HI), [31:0] = quotient (LO); registered.
REQ-009 The block SHALL have the port `ready_o`: output, 1 bit; result valid; registered.

Function
REQ-010 The FSM SHALL have exactly four states: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END.
REQ-011 In DIV_FREE with start_i=1 and annul_i=0, the next state SHALL be DIV_BY_ZERO if opdata2_i==0, else DIV_ON.
- On entering DIV_ON: iteration counter = 0.
- Operands are latched on the same edge.
REQ-012 In DIV_FREE with start_i=0 or annul_i=1, the block SHALL remain in DIV_FREE with ready_o=0 and result_o=0.
REQ-013 Signed mode SHALL latch the two's-complement magnitude of each negative operand; unsigned mode SHALL latch operands unchanged.
REQ-014 DIV_ON SHALL perform one restoring shift-subtract iteration per cycle on a 65-bit working register: 33-bit partial remainder, 32-bit quotient.
REQ-015 The counter SHALL increment once per DIV_ON cycle, and the state SHALL move to DIV_END on the edge that completes iteration 32 (counter 31 -> done).
REQ-016 On the DIV_ON -> DIV_END edge, sign correction SHALL be applied in signed mode.
- Quotient is negated iff the dividend sign differs from the divisor sign.
- Remainder is negated iff the dividend is negative.
- The corrected values are registered into result_o, and ready_o=1.
REQ-017 DIV_BY_ZERO SHALL go to DIV_END on the next edge with result_o=64'h0 and ready_o=1.
REQ-018 In DIV_END, result_o and ready_o=1 SHALL hold while start_i=1.
- When start_i=0: next state DIV_FREE, ready_o=0, result_o=0.
REQ-019 annul_i=1 in DIV_ON SHALL force DIV_FREE on the next edge with ready_o=0, and no result SHALL be produced.
REQ-020 annul_i SHALL be ignored in DIV_BY_ZERO and DIV_END.
REQ-021 Latency SHALL be as follows.
- Nonzero divisor: ready_o rises on the 33rd rising edge counting the start-accept edge as 1.
- Zero divisor: ready_o rises on the 2nd edge.
REQ-022 Operand inputs SHALL be ignored after acceptance; changes during DIV_ON/DIV_END SHALL NOT affect the result.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0, with no trap and no special state.
REQ-024 Start SHALL NOT be re-accepted until DIV_FREE is re-entered.
- Back-to-back divides cost at least one DIV_FREE cycle between them.

Reset
REQ-025 rst=1 SHALL immediately (asynchronously), in any state including mid-divide, force DIV_FREE, counter=0, working register=0, result_o=64'h0, ready_o=0.
REQ-026 After rst deasserts, the first operation SHALL start only from a fresh start_i sample in DIV_FREE.

Verification
REQ-027 Unsigned: signed_div_i=0, opdata1_i=100, opdata2_i=7, start_i=1 -> ready_o=1 on edge 33, result_o=64'h00000002_0000000E.
REQ-028 Signed: signed_div_i=1, opdata1_i=0xFFFFFFF9 (-7), opdata2_i=2 -> result_o=64'hFFFFFFFF_FFFFFFFD (r=-1, q=-3).
REQ-029 Divide by zero: opdata1_i=5, opdata2_i=0, start_i=1 -> ready_o=1 on edge 2, result_o=0.
- Then start_i=0 -> ready_o=0 on the next edge.
REQ-030 Annul: unsigned 0xFFFFFFFF/3, annul_i=1 at edge 10 -> state DIV_FREE and ready_o never rises.
- A following 9/3 request -> result_o=64'h00000000_00000003.
REQ-031 Overflow corner: signed 0x80000000 / 0xFFFFFFFF -> result_o=64'h00000000_80000000.
- Also: unsigned 0xFFFFFFFF/1 -> 64'h00000000_FFFFFFFF.
REQ-032 Reset mid-op: rst pulsed at edge 15 of a divide -> outputs 0 immediately, without waiting for a clock edge.
- A new 100/7 request after release -> correct result with full 33-edge latency.
